// File: rtl/irq_pkg.sv
// Shared constants and state encoding for the interrupt dispatch sequencer.
package irq_pkg;

    localparam int unsigned N        = 5;
    localparam int unsigned LAT      = N * (N + 1) / 2;
    localparam logic [2:0]  PRI_IDLE = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

endpackage

// File: rtl/irq_isr_stack.sv
// LIFO of in-service {line, pri} entries; a same-cycle pop and push replaces the top.
module irq_isr_stack
    import irq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] push_line,
    input  logic [2:0]   push_pri,
    output logic [N-1:0] top_line,
    output logic [2:0]   top_pri,
    output logic [2:0]   depth
);

    localparam int unsigned SLOTS    = 8;
    localparam logic [2:0]  DEPTH_LIM = 3'(DEPTH);

    logic [N-1:0] line_q [SLOTS];
    logic [2:0]   pri_q  [SLOTS];
    logic [2:0]   cnt;
    logic [2:0]   top_idx;
    logic [2:0]   wr_idx;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok  = pop && (cnt != 3'd0);
    assign push_ok = push && (pop_ok || (cnt < DEPTH_LIM));
    assign top_idx = cnt - 3'd1;
    // Popping first means the new entry lands where the old top was.
    assign wr_idx  = pop_ok ? top_idx : cnt;

    assign top_line = (cnt == 3'd0) ? '0 : line_q[top_idx];
    assign top_pri  = (cnt == 3'd0) ? '0 : pri_q[top_idx];
    assign depth    = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (push_ok && !pop_ok) begin
            cnt <= cnt + 3'd1;
        end else if (pop_ok && !push_ok) begin
            cnt <= cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            line_q[wr_idx] <= push_line;
            pri_q[wr_idx]  <= push_pri;
        end
    end

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatch sequencer: request/ack/EOI handshake, in-service mask, sorter settle wait.
// IRQ_NEST_EN enables DEPTH-level preemptive nesting; otherwise one interrupt is in service at a time.
module irq_dispatch
    import irq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cand_vld,
    input  logic [N-1:0]      cand_line,
    input  logic [2:0]        cand_pri,
    output logic              irq_out,
    output logic [N-1:0]      irq_code,
    input  logic              irq_ack,
    input  logic              irq_eoi,
    output logic [2**N-1:0]   isr_mask,
    output logic [2:0]        cur_pri,
    output logic [2:0]        depth,
    output logic              eoi_err
);

`ifdef IRQ_NEST_EN
    localparam int unsigned EFF_DEPTH = DEPTH;
`else
    localparam int unsigned EFF_DEPTH = 1;
`endif
    localparam logic [2:0]  DEPTH_LIM = 3'(EFF_DEPTH);
    localparam int unsigned SW        = $clog2(LAT + 1);

    state_t          state, state_nx;
    logic [SW-1:0]   settle;
    logic [2:0]      pend_pri;
    logic [N-1:0]    top_line;
    logic [2:0]      top_pri;
    logic [3:0]      thr;
    logic            eligible;
    logic            take;
    logic            do_push;
    logic            do_pop;
    logic [2**N-1:0] mask_nx;

    irq_isr_stack #(
        .DEPTH(EFF_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .pop       (do_pop),
        .push_line (irq_code),
        .push_pri  (pend_pri),
        .top_line  (top_line),
        .top_pri   (top_pri),
        .depth     (depth)
    );

    assign cur_pri  = (depth == 3'd0) ? PRI_IDLE : top_pri;
    assign thr      = (depth == 3'd0) ? 4'd8 : {1'b0, cur_pri};
    assign eligible = cand_vld && (settle == '0) && ({1'b0, cand_pri} < thr)
                      && (depth < DEPTH_LIM);
    assign do_push  = (state == REQ) && irq_ack;
    assign do_pop   = irq_eoi && (depth != 3'd0);

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            IDLE: begin
                if (eligible) begin
                    take     = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (irq_ack) state_nx = SVC;
            end
            SVC: begin
                if (do_pop) begin
                    if (depth == 3'd1) state_nx = IDLE;
                end
`ifdef IRQ_NEST_EN
                else if (eligible) begin
                    take     = 1'b1;
                    state_nx = REQ;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // Clear of the popped line precedes the set of the pushed one.
    always_comb begin
        mask_nx = isr_mask;
        if (do_pop)  mask_nx[top_line] = 1'b0;
        if (do_push) mask_nx[irq_code] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            irq_out  <= 1'b0;
            irq_code <= '0;
            pend_pri <= '0;
            settle   <= '0;
            isr_mask <= '0;
            eoi_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            irq_out  <= (state_nx == REQ);
            isr_mask <= mask_nx;
            if (take) begin
                irq_code <= cand_line;
                pend_pri <= cand_pri;
            end
            if (do_push || do_pop) begin
                settle <= SW'(LAT);
            end else if (settle != '0) begin
                settle <= settle - 1'b1;
            end
            if (irq_eoi && (depth == 3'd0)) eoi_err <= 1'b1;
        end
    end

endmodule
